dmem_lsu: RTL
=============

# dmem_lsu

Parametrised 32-bit data memory with integrated load/store formatting for the pipelined core's memory stage. It replaces four per-lane byte memories with one word-wide array that has byte-lane write enables, RV32I load sign/zero extension and store lane steering. A reset-time clear sequencer zeroes the whole array. All accesses are single-port, synchronous write and registered read, so the array maps to BRAM.

## Interface
- ADDR_W, 11, byte-address bits decoded; DEPTH = 2**(ADDR_W-2) words (default 512 words = 2KiB)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req  input  1  access request this cycle
- we  input  1  1 = store, 0 = load (qualified by req)
- addr  input  32  byte address; bits [31:ADDR_W] ignored
- size  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- wr_data  input  32  store data, LSB-justified
- rd_data  output  32  formatted load result
- rd_valid  output  1  rd_data updated this cycle
- misalign  output  1  previous request was rejected
- busy  output  1  clear sequence in progress; requests ignored

## Operation
- FSM states: CLEAR, RUN.
- While rst=1: state<=CLEAR, clear counter<=0, rd_data<=0, rd_valid<=0, misalign<=0.
- CLEAR:
  - Each cycle with rst=0, write word[cnt]<=0 and increment cnt.
  - At cnt==DEPTH-1, go to RUN.
  - busy = (state==CLEAR), so busy reads 1 throughout reset.
- RUN, req=1, we=1 (store):
  - Word index = addr[ADDR_W-1:2].
  - Byte store: lane addr[1:0] <= wr_data[7:0].
  - Half store: lanes {addr[1],0}..+1 <= wr_data[15:0].
  - Word store: all four lanes are written.
  - Unwritten lanes keep their contents.
  - rd_valid stays 0.
- RUN, req=1, we=0 (load):
  - Word read is registered. size and addr[1:0] are registered alongside it.
  - The selected byte or half is sign-extended (B/H) or zero-extended (BU/HU).
- Illegal size codes (011, 110, 111), and size 1xx with we=1:
  - No write; the load does not complete.
  - Handled as a rejected access (see Configuration).
- req=0 or busy=1: no memory access. Outputs update only as defined in Timing.
- Address wrap-around: addresses differing only above ADDR_W alias the same word.
- Store and load never share a cycle (single port). A load in the cycle after a store to the same word returns the new data.

## Timing
- Load issued in cycle N: rd_valid=1 and rd_data valid in cycle N+1. rd_valid is a one-cycle pulse per load.
- rd_data holds its last value when rd_valid=0.
- Store issued in cycle N: memory is updated at the end of cycle N.
- Rejected request in cycle N: misalign=1 in cycle N+1 for one cycle, and rd_valid=0.
- Clear sequence: the first cycle with rst=0 is C0. busy=1 for cycles C0..C0+DEPTH-1. busy=0 from C0+DEPTH. The first accepted request is in cycle C0+DEPTH.
- Reset asserted mid-clear or mid-access:
  - Counter restarts at 0.
  - A pending rd_valid or misalign is dropped (0 next cycle).
- Back-to-back loads: one result per cycle, no bubbles.

## Configuration
- DMEM_MISALIGN_EN defined:
  - Rejected accesses: half with addr[0]=1, word with addr[1:0]!=0, and illegal size codes.
  - A rejected access performs no write and no load, and pulses misalign.
- DMEM_MISALIGN_EN undefined:
  - misalign is tied 0.
  - Offset bits below access size are ignored: half uses addr[1] only, word ignores addr[1:0].
  - Illegal size codes are silent no-ops: no write, rd_valid=0.

## Test plan
- Reset then clear:
  - Stimulus: rst high 2 cycles, release, DEPTH=512.
  - Required: busy=1 for exactly 512 cycles.
  - Required: a LW at any address, e.g. 0x7FC, then returns 0x00000000.
- Lane stores/loads:
  - Stimulus: SW 0x11223344 @0x10; SB 0xAA @0x11; SH 0xBEEF @0x12.
  - Required: LW @0x10 returns 0xBEEFAA44.
  - Required: LB @0x11 returns 0xFFFFFFAA; LBU @0x11 returns 0x000000AA.
  - Required: LH @0x12 returns 0xFFFFBEEF; LHU @0x12 returns 0x0000BEEF.
- Alias/wrap:
  - Stimulus: SW 0xCAFEF00D @0x00000804 (ADDR_W=11).
  - Required: LW @0x004 returns 0xCAFEF00D.
- Back-to-back and holding:
  - Stimulus: loads in cycles N, N+1, N+2 to three different words.
  - Required: three consecutive rd_valid pulses with matching data; rd_data unchanged at N+4 when idle.
- Misaligned, with DMEM_MISALIGN_EN:
  - Stimulus: SW 0xFFFFFFFF @0x21.
  - Required: misalign=1 next cycle; LW @0x20 still returns its prior value.
  - Required: the same store without the macro writes word 0x20 with 0xFFFFFFFF and misalign stays 0.
- Reset mid-operation:
  - Stimulus: rst asserted in the cycle after a load request, and separately at clear count 100.
  - Required: rd_valid=0 after the reset.
  - Required: busy persists for a full 512 cycles after release.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: word-wide data memory with byte-lane stores, RV32I load formatting and a reset-time clear.
// Load latency 1 cycle, stores commit at the cycle edge; requests are ignored while busy. Optional macro: DMEM_MISALIGN_EN.
module dmem_lsu #(
    parameter int ADDR_W = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        misalign,
    output logic        busy
);
    localparam int IW    = ADDR_W - 2;
    localparam int DEPTH = 2 ** IW;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic            rd_valid_q, rd_valid_d;
    logic            misalign_q, misalign_d;
    logic [2:0]      size_q, size_d;
    logic [1:0]      off_q, off_d;
    logic [31:0]     rd_word_q;

    logic [31:0]     mem [DEPTH];

    logic            acc, legal, reject, st_en, ld_en;
    logic [1:0]      off_eff;
    logic [IW-1:0]   widx;
    logic            mem_we;
    logic [IW-1:0]   mem_idx;
    logic [3:0]      mem_be;
    logic [31:0]     mem_wdat;
    logic [31:0]     lane;
    logic            unused_ok;

    assign unused_ok = ^{addr[31:ADDR_W]};

    always_comb begin
        acc     = (state_q == RUN) && req && !rst;
        widx    = addr[ADDR_W-1:2];
        case (size)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !we;
            default:                legal = 1'b0;
        endcase
`ifdef DMEM_MISALIGN_EN
        reject = !legal
               || (size[1:0] == 2'b01 && addr[0])
               || (size[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
        reject = !legal;
`endif
        // Offset bits below the access size are dropped so unaligned accesses fold onto the aligned lanes.
        off_eff = size[1] ? 2'b00 : (size[0] ? {addr[1], 1'b0} : addr[1:0]);
        st_en   = acc && we && !reject;
        ld_en   = acc && !we && !reject;

        mem_we   = (state_q == CLEAR) && !rst;
        mem_idx  = cnt_q;
        mem_be   = 4'hf;
        mem_wdat = 32'h0;
        if (st_en) begin
            mem_we  = 1'b1;
            mem_idx = widx;
            case (size[1:0])
                2'b00: begin
                    mem_be   = 4'b0001 << off_eff;
                    mem_wdat = {4{wr_data[7:0]}};
                end
                2'b01: begin
                    mem_be   = off_eff[1] ? 4'b1100 : 4'b0011;
                    mem_wdat = {2{wr_data[15:0]}};
                end
                default: begin
                    mem_be   = 4'hf;
                    mem_wdat = wr_data;
                end
            endcase
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IW'(DEPTH - 1))
                state_d = RUN;
        end
        rd_valid_d = ld_en;
`ifdef DMEM_MISALIGN_EN
        misalign_d = acc && reject;
`else
        misalign_d = 1'b0;
`endif
        size_d = ld_en ? size    : size_q;
        off_d  = ld_en ? off_eff : off_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            size_q     <= 3'b000;
            off_q      <= 2'b00;
            rd_word_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            misalign_q <= misalign_d;
            size_q     <= size_d;
            off_q      <= off_d;
            if (ld_en)
                rd_word_q <= mem[widx];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i])
                    mem[mem_idx][8*i +: 8] <= mem_wdat[8*i +: 8];
            end
        end
    end

    // Formatting sits after the read register so rd_data holds while no new load lands.
    always_comb begin
        lane = rd_word_q >> {off_q, 3'b000};
        case (size_q)
            3'b000:  rd_data = {{24{lane[7]}}, lane[7:0]};
            3'b100:  rd_data = {24'h0, lane[7:0]};
            3'b001:  rd_data = {{16{lane[15]}}, lane[15:0]};
            3'b101:  rd_data = {16'h0, lane[15:0]};
            default: rd_data = rd_word_q;
        endcase
    end

    assign rd_valid = rd_valid_q;
    assign misalign = misalign_q;
    assign busy     = (state_q == CLEAR);
endmodule
